shadow_chain_arbiter: RTL and testbench
=======================================

Name: shadow_chain_arbiter

Overview:
- Child-chain arbiter inside each shadow-capture node.
- After the node's local shadow bits have been dumped, it routes the serial dump chains of CHAINS_IN child nodes onto the node's CHAINS_OUT parent chains, one child per output chain at a time.
- It issues per-child dump commands and reports per-output completion.
- Holds a registered per-output child pointer; the muxing is combinational.

Parameters:
- CHAINS_IN, 1, number of child chains; 0 means no children, and all child ports are then 1 bit wide and ignored.
- CHAINS_OUT, 1, number of parent output chains; must be at least 1.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- cin, input, max(CHAINS_IN,1): serial data from the child chains.
- cin_vld, input, max(CHAINS_IN,1): child data valid.
- cin_status, input, max(CHAINS_IN,1): child i has finished dumping; level, held high until reset.
- local_done, input, 1: the node's local dump is complete; arbitration is enabled only while high.
- cout, output, CHAINS_OUT: routed child data.
- cout_vld, output, CHAINS_OUT: routed child valid.
- cout_status, output, CHAINS_OUT: all children assigned to output j are done.
- dump_cmd, output, max(CHAINS_IN,1): dump enable to child i.

Behaviour:
- Static assignment: child i belongs to output j = i mod CHAINS_OUT.
- Children of output j are served in ascending index order: j, j+CHAINS_OUT, j+2·CHAINS_OUT, and so on.
- An output with no assigned children (j ≥ CHAINS_IN):
  - cout[j]=0, cout_vld[j]=0, cout_status[j]=1.
- Per-output state is a registered pointer ptr[j], holding the index of the child currently being served.
- Reset (rst=0, asynchronous): ptr[j] is set to the first assigned child (j).
- Outputs during reset:
  - cout=0, cout_vld=0, dump_cmd=0.
  - cout_status follows the combinational rule below and is not forced.
- Pointer advance, per output j, on a clock edge while rst=1:
  - Condition: local_done=1, cin_status[ptr[j]]=1, and ptr[j] is not the last assigned child.
  - Action: ptr[j] ← ptr[j]+CHAINS_OUT.
  - Only one step per cycle. An already-done next child costs one extra cycle and is then skipped.
  - When the last child is done, ptr[j] holds.
- dump_cmd[i] = local_done & (ptr[owner(i)] == i) & ~cin_status[i]. Combinational, so at most one child per output is commanded at a time.
- Routing while local_done=1 and cin_status[ptr[j]]=0:
  - cout[j]=cin[ptr[j]] and cout_vld[j]=cin_vld[ptr[j]], combinational with zero latency.
  - Otherwise cout[j]=0 and cout_vld[j]=0.
- cout_status[j] = AND of cin_status over all children assigned to j. Combinational; independent of local_done.
- While local_done=0: ptr holds, dump_cmd=0, cout=0, cout_vld=0.
- local_done may drop mid-dump; arbitration resumes from the held ptr when it returns high.
- CHAINS_IN=0:
  - dump_cmd=1 (constant).
  - cout=0, cout_vld=0, cout_status all 1.
  - No state.
- Reset mid-dump restarts every pointer at its first child; child progress is not remembered.
- cin_status dropping back to 0 is not expected. ptr never moves backwards; dump_cmd re-asserts for the current child only.
- Widths: ptr[j] is clog2(max(CHAINS_IN,2)) bits wide; index arithmetic never exceeds CHAINS_IN-1.

Test Plan:
- Reset routing: CHAINS_IN=4, CHAINS_OUT=2, rst=0 then 1, local_done=0 -> dump_cmd=0000, cout=00, cout_vld=00, cout_status=00.
- First grant: set local_done=1, cin=4'b0011, cin_vld=4'b1111 -> dump_cmd=0011, cout=2'b11, cout_vld=11 in the same cycle.
- Pointer advance: raise cin_status[0] -> dump_cmd[0]=0 immediately; next edge dump_cmd=0110 and cout[0]=cin[2]. Raise cin_status[2] -> cout[0]=0, cout_vld[0]=0, cout_status[0]=1 once cin_status[0] and cin_status[2] are both 1.
- Unassigned output: CHAINS_IN=1, CHAINS_OUT=3 -> cout_status[2:1]=11 and cout[2:1]=00 always; output 0 serves child 0 only.
- Skip done child: CHAINS_IN=3, CHAINS_OUT=1, cin_status=3'b011 preset, local_done=1 -> dump_cmd=000 for 2 cycles, then dump_cmd=100 and cout=cin[2].
- Async reset mid-dump: with ptr[0]=2, pulse rst low between edges -> ptr[0]=0 immediately and dump_cmd=0 while rst is low. CHAINS_IN=0 -> dump_cmd=1, cout_status all 1.

Source files
------------

// File: rtl/shadow_chain_arbiter_if.sv
// Bundle between a shadow-capture node's child chains and its parent chains.
// The master drives the child-side inputs; the arbiter (slave) drives the routed outputs.
interface shadow_chain_arbiter_if #(
  parameter int CHAINS_IN  = 1,
  parameter int CHAINS_OUT = 1
);
  localparam int NI = (CHAINS_IN > 0) ? CHAINS_IN : 1;

  logic [NI-1:0]         cin;
  logic [NI-1:0]         cin_vld;
  logic [NI-1:0]         cin_status;
  logic [NI-1:0]         dump_cmd;
  logic                  local_done;
  logic [CHAINS_OUT-1:0] cout;
  logic [CHAINS_OUT-1:0] cout_vld;
  logic [CHAINS_OUT-1:0] cout_status;

  modport master (
    output cin, cin_vld, cin_status, local_done,
    input  dump_cmd, cout, cout_vld, cout_status
  );

  modport slave (
    input  cin, cin_vld, cin_status, local_done,
    output dump_cmd, cout, cout_vld, cout_status
  );
endinterface

// File: rtl/shadow_chain_arbiter.sv
// Routes child dump chains onto parent chains, one child per output at a time.
// Child i belongs to output i mod CHAINS_OUT; each output walks its children in ascending order.
module shadow_chain_arbiter #(
  parameter int CHAINS_IN  = 1,
  parameter int CHAINS_OUT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  shadow_chain_arbiter_if.slave bus
);
  localparam int PW = $clog2((CHAINS_IN > 2) ? CHAINS_IN : 2);

  generate
    if (CHAINS_IN == 0) begin : g_leaf
      assign bus.dump_cmd    = 1'b1;
      assign bus.cout        = '0;
      assign bus.cout_vld    = '0;
      assign bus.cout_status = '1;
    end else begin : g_arb
      for (genvar j = 0; j < CHAINS_OUT; j++) begin : g_out
        if (j < CHAINS_IN) begin : g_used
          localparam int LAST = j + ((CHAINS_IN - 1 - j) / CHAINS_OUT) * CHAINS_OUT;
          localparam int NOWN = (LAST - j) / CHAINS_OUT + 1;

          logic [PW-1:0]   ptr_q, ptr_d;
          logic [NOWN-1:0] own_sel, own_s, own_d, own_v;
          logic            cur_s;
          logic            route;

          // Local view of the children this output owns; own_sel is one-hot on ptr_q.
          for (genvar k = 0; k < NOWN; k++) begin : g_child
            localparam int I = j + k * CHAINS_OUT;
            assign own_sel[k]       = (ptr_q == PW'(I));
            assign own_s[k]         = bus.cin_status[I];
            assign own_d[k]         = bus.cin[I];
            assign own_v[k]         = bus.cin_vld[I];
            assign bus.dump_cmd[I]  = rst & bus.local_done & own_sel[k] & ~own_s[k];
          end

          assign cur_s               = |(own_sel & own_s);
          assign route               = rst & bus.local_done & ~cur_s;
          assign bus.cout[j]         = route & |(own_sel & own_d);
          assign bus.cout_vld[j]     = route & |(own_sel & own_v);
          assign bus.cout_status[j]  = &own_s;

          // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
          always_comb begin
            ptr_d = ptr_q;
            if (bus.local_done && cur_s && (ptr_q != PW'(LAST)))
              ptr_d = ptr_q + PW'(CHAINS_OUT);
          end

          // NOTE: sequential state uses non-blocking assignment so all flops update together on the edge.
          always_ff @(posedge clk or negedge rst) begin
            if (!rst) ptr_q <= PW'(j);
            else      ptr_q <= ptr_d;
          end
        end else begin : g_idle
          assign bus.cout[j]        = 1'b0;
          assign bus.cout_vld[j]    = 1'b0;
          assign bus.cout_status[j] = 1'b1;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_shadow_chain_arbiter.sv
// Directed bench for shadow_chain_arbiter across four parameterisations (4/2, 1/3, 3/1, 0/2).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later or 1 after a rising edge.
module tb_shadow_chain_arbiter;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c, rst_d;
  int   errors = 0;
  int   n_checks = 0;

  always #5 clk = ~clk;

  shadow_chain_arbiter_if #(.CHAINS_IN(4), .CHAINS_OUT(2)) if_a ();
  shadow_chain_arbiter_if #(.CHAINS_IN(1), .CHAINS_OUT(3)) if_b ();
  shadow_chain_arbiter_if #(.CHAINS_IN(3), .CHAINS_OUT(1)) if_c ();
  shadow_chain_arbiter_if #(.CHAINS_IN(0), .CHAINS_OUT(2)) if_d ();

  shadow_chain_arbiter #(.CHAINS_IN(4), .CHAINS_OUT(2)) u_a (.clk(clk), .rst(rst_a), .bus(if_a));
  shadow_chain_arbiter #(.CHAINS_IN(1), .CHAINS_OUT(3)) u_b (.clk(clk), .rst(rst_b), .bus(if_b));
  shadow_chain_arbiter #(.CHAINS_IN(3), .CHAINS_OUT(1)) u_c (.clk(clk), .rst(rst_c), .bus(if_c));
  shadow_chain_arbiter #(.CHAINS_IN(0), .CHAINS_OUT(2)) u_d (.clk(clk), .rst(rst_d), .bus(if_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_slot();
    @(negedge clk);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    if_a.cin = '0; if_a.cin_vld = '0; if_a.cin_status = '0; if_a.local_done = 1'b0;
    if_b.cin = '0; if_b.cin_vld = '0; if_b.cin_status = '0; if_b.local_done = 1'b0;
    if_c.cin = '0; if_c.cin_vld = '0; if_c.cin_status = '0; if_c.local_done = 1'b0;
    if_d.cin = '0; if_d.cin_vld = '0; if_d.cin_status = '0; if_d.local_done = 1'b0;

    // ---------------- 4 children, 2 outputs ----------------
    drive_slot();
    if_a.cin = 4'b1111; if_a.cin_vld = 4'b1111; if_a.local_done = 1'b1;
    #1;
    check("a_rst_dump_cmd", 32'(if_a.dump_cmd), 32'h0);
    check("a_rst_cout",     32'(if_a.cout),     32'h0);
    check("a_rst_vld",      32'(if_a.cout_vld), 32'h0);
    check("a_rst_status",   32'(if_a.cout_status), 32'h0);

    drive_slot();
    if_a.local_done = 1'b0; rst_a = 1'b1;
    after_edge();
    check("a_idle_dump_cmd", 32'(if_a.dump_cmd), 32'h0);
    check("a_idle_cout",     32'(if_a.cout),     32'h0);
    check("a_idle_vld",      32'(if_a.cout_vld), 32'h0);
    check("a_idle_status",   32'(if_a.cout_status), 32'h0);

    drive_slot();
    if_a.local_done = 1'b1; if_a.cin = 4'b0011; if_a.cin_vld = 4'b1111;
    #1;
    check("a_grant_dump_cmd", 32'(if_a.dump_cmd), 32'h3);
    check("a_grant_cout",     32'(if_a.cout),     32'h3);
    check("a_grant_vld",      32'(if_a.cout_vld), 32'h3);
    after_edge();
    check("a_grant_hold", 32'(if_a.dump_cmd), 32'h3);

    drive_slot();
    if_a.cin_status = 4'b0001;
    #1;
    check("a_done0_dump_cmd", 32'(if_a.dump_cmd), 32'h2);
    check("a_done0_cout",     32'(if_a.cout),     32'h2);
    check("a_done0_vld",      32'(if_a.cout_vld), 32'h2);
    after_edge();
    check("a_adv_dump_cmd", 32'(if_a.dump_cmd), 32'h6);
    check("a_adv_cout_c2_0", 32'(if_a.cout), 32'h2);
    drive_slot();
    if_a.cin = 4'b0100;
    #1;
    check("a_adv_cout_c2_1", 32'(if_a.cout), 32'h1);

    drive_slot();
    if_a.cin_status = 4'b0101;
    #1;
    check("a_last_cout",     32'(if_a.cout),     32'h0);
    check("a_last_vld",      32'(if_a.cout_vld), 32'h2);
    check("a_last_status",   32'(if_a.cout_status), 32'h1);
    check("a_last_dump_cmd", 32'(if_a.dump_cmd), 32'h2);
    after_edge();
    check("a_last_hold", 32'(if_a.dump_cmd), 32'h2);

    drive_slot();
    if_a.local_done = 1'b0;
    #1;
    check("a_ld0_dump_cmd", 32'(if_a.dump_cmd), 32'h0);
    check("a_ld0_cout",     32'(if_a.cout_vld), 32'h0);
    check("a_ld0_status",   32'(if_a.cout_status), 32'h1);
    drive_slot();
    if_a.local_done = 1'b1;
    #1;
    check("a_resume_dump_cmd", 32'(if_a.dump_cmd), 32'h2);

    // Mid-dump reset: children reset too, so status clears while rst is low.
    drive_slot();
    #2;
    rst_a = 1'b0;
    #1;
    check("a_mid_rst_dump_cmd", 32'(if_a.dump_cmd), 32'h0);
    check("a_mid_rst_vld",      32'(if_a.cout_vld), 32'h0);
    if_a.cin_status = 4'b0000;
    #1;
    rst_a = 1'b1;
    #1;
    check("a_post_rst_dump_cmd", 32'(if_a.dump_cmd), 32'h3);
    check("a_post_rst_status",   32'(if_a.cout_status), 32'h0);

    // ---------------- 1 child, 3 outputs ----------------
    drive_slot();
    rst_b = 1'b1; if_b.local_done = 1'b1; if_b.cin = 1'b1; if_b.cin_vld = 1'b1;
    #1;
    check("b_dump_cmd", 32'(if_b.dump_cmd), 32'h1);
    check("b_cout",     32'(if_b.cout),     32'h1);
    check("b_vld",      32'(if_b.cout_vld), 32'h1);
    check("b_status",   32'(if_b.cout_status), 32'h6);
    after_edge();
    check("b_cout_hold", 32'(if_b.cout), 32'h1);
    drive_slot();
    if_b.cin_status = 1'b1;
    #1;
    check("b_done_dump_cmd", 32'(if_b.dump_cmd), 32'h0);
    check("b_done_cout",     32'(if_b.cout),     32'h0);
    check("b_done_status",   32'(if_b.cout_status), 32'h7);
    after_edge();
    check("b_done_vld", 32'(if_b.cout_vld), 32'h0);

    // ---------------- 3 children, 1 output, skip done ----------------
    drive_slot();
    if_c.cin_status = 3'b011; if_c.local_done = 1'b1;
    if_c.cin = 3'b100; if_c.cin_vld = 3'b100;
    rst_c = 1'b1;
    #1;
    check("c_skip0_dump_cmd", 32'(if_c.dump_cmd), 32'h0);
    after_edge();
    check("c_skip1_dump_cmd", 32'(if_c.dump_cmd), 32'h0);
    after_edge();
    check("c_skip2_dump_cmd", 32'(if_c.dump_cmd), 32'h4);
    check("c_skip2_cout",     32'(if_c.cout),     32'h1);
    check("c_skip2_vld",      32'(if_c.cout_vld), 32'h1);
    check("c_skip2_status",   32'(if_c.cout_status), 32'h0);
    drive_slot();
    if_c.cin = 3'b011;
    #1;
    check("c_mux_bit2", 32'(if_c.cout), 32'h0);
    drive_slot();
    if_c.cin_status = 3'b111;
    #1;
    check("c_all_status",   32'(if_c.cout_status), 32'h1);
    check("c_all_dump_cmd", 32'(if_c.dump_cmd), 32'h0);

    // ---------------- no children ----------------
    drive_slot();
    if_d.cin = 1'b1; if_d.cin_vld = 1'b1; if_d.local_done = 1'b1;
    #1;
    check("d_rst_dump_cmd", 32'(if_d.dump_cmd), 32'h1);
    check("d_rst_status",   32'(if_d.cout_status), 32'h3);
    rst_d = 1'b1;
    after_edge();
    check("d_dump_cmd", 32'(if_d.dump_cmd), 32'h1);
    check("d_cout",     32'(if_d.cout),     32'h0);
    check("d_vld",      32'(if_d.cout_vld), 32'h0);
    check("d_status",   32'(if_d.cout_status), 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end
endmodule
